// File: rtl/idu_pkg.sv
// Shared decode constants and packet type for the IDU; also used by IFU/EXU.
package idu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, UPPER
    } d_type_e;

    typedef struct packed {
        logic [XLEN-1:0] ip;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic            rd_we;
        d_type_e         typ;
        logic [3:0]      func;
        logic            illegal;
    } pkt_t;

    localparam pkt_t PKT_RST = '{ip: '0, rs1: '0, rs2: '0, imm: '0, rd: '0, rd_we: 1'b0,
                                 typ: ALU_I, func: '0, illegal: 1'b0};

endpackage

// File: rtl/idu_imm_gen.sv
// Combinational immediate generator: I/S/B/U/J formats, sign-extended; 0 otherwise.
module idu_imm_gen
    import idu_pkg::*;
(
    input  logic [31:0]     IR,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        imm = '0;
        case (IR[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{IR[31]}}, IR[31:20]};
            OPC_STORE:
                imm = {{20{IR[31]}}, IR[31:25], IR[11:7]};
            OPC_BRANCH:
                imm = {{19{IR[31]}}, IR[31], IR[7], IR[30:25], IR[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {IR[31:12], 12'b0};
            OPC_JAL:
                imm = {{11{IR[31]}}, IR[31], IR[19:12], IR[20], IR[30:21], 1'b0};
            default:
                imm = '0;
        endcase
    end

endmodule

// File: rtl/idu.sv
// Decode stage: handshake/flush control, RV32I decode, write-back forwarding, packet register.
// Optional IDU_ILLEGAL_DET_EN flags unsupported encodings instead of decoding them as NOP.
module idu
    import idu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     IR,
    input  logic [XLEN-1:0] ip,
    input  logic            IFU_valid,
    output logic            IDU_ready,
    input  logic            jump,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            IDU_valid,
    input  logic            EXU_ready,
    output logic [XLEN-1:0] d_ip,
    output logic [XLEN-1:0] d_rs1,
    output logic [XLEN-1:0] d_rs2,
    output logic [XLEN-1:0] d_imm,
    output logic [4:0]      d_rd,
    output logic            d_rd_we,
    output logic [2:0]      d_type,
    output logic [3:0]      d_func,
    output logic            d_illegal
);

    logic            valid_q;
    pkt_t            pkt_q;
    pkt_t            dec;
    logic [XLEN-1:0] imm;
    logic            accept;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            wr_rd;

    assign opc      = IR[6:0];
    assign f3       = IR[14:12];
    assign rs1_addr = IR[19:15];
    assign rs2_addr = IR[24:20];

    assign IDU_ready = !valid_q || EXU_ready;
    assign accept    = IFU_valid && IDU_ready && !jump;

    idu_imm_gen u_imm_gen (
        .IR  (IR),
        .imm (imm)
    );

    always_comb begin
        dec     = PKT_RST;
        wr_rd   = 1'b0;
        dec.ip  = ip;
        dec.imm = imm;
        // x0 reads as zero even if the write-back port targets it
        dec.rs1 = (rs1_addr == 5'd0) ? '0 :
                  (wb_en && wb_rd == rs1_addr) ? wb_data : rs1_data;
        dec.rs2 = (rs2_addr == 5'd0) ? '0 :
                  (wb_en && wb_rd == rs2_addr) ? wb_data : rs2_data;
        case (opc)
            OPC_OP: begin
                dec.typ  = ALU_R;
                dec.func = {IR[30], f3};
                wr_rd    = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.typ  = ALU_I;
                dec.func = {(f3[1:0] == 2'b01) ? IR[30] : 1'b0, f3};
                wr_rd    = 1'b1;
            end
            OPC_LOAD: begin
                dec.typ  = LOAD;
                dec.func = {1'b0, f3};
                wr_rd    = 1'b1;
            end
            OPC_STORE: begin
                dec.typ  = STORE;
                dec.func = {1'b0, f3};
            end
            OPC_BRANCH: begin
                dec.typ  = BRANCH;
                dec.func = {1'b0, f3};
            end
            OPC_JAL: begin
                dec.typ = JAL;
                wr_rd   = 1'b1;
            end
            OPC_JALR: begin
                dec.typ  = JALR;
                dec.func = {1'b0, f3};
                wr_rd    = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec.typ  = UPPER;
                dec.func = {3'b000, opc[5]};
                wr_rd    = 1'b1;
            end
            default: begin
                dec.typ = ALU_I;
            end
        endcase
        dec.rd    = wr_rd ? IR[11:7] : 5'd0;
        dec.rd_we = wr_rd && (IR[11:7] != 5'd0);
`ifdef IDU_ILLEGAL_DET_EN
        case (opc)
            OPC_OP:
                dec.illegal = !((IR[31:25] == 7'b0000000) ||
                                (IR[31:25] == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            OPC_OP_IMM:
                dec.illegal = (f3 == 3'b001 && IR[31:25] != 7'b0000000) ||
                              (f3 == 3'b101 && IR[31:25] != 7'b0000000 &&
                               IR[31:25] != 7'b0100000);
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC,
            OPC_FENCE, OPC_SYSTEM:
                dec.illegal = 1'b0;
            default:
                dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.rd_we = 1'b0;
            dec.typ   = ALU_I;
        end
`else
        dec.illegal = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pkt_q   <= PKT_RST;
        end else if (jump) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            pkt_q   <= dec;
        end else if (EXU_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign IDU_valid = valid_q;
    assign d_ip      = pkt_q.ip;
    assign d_rs1     = pkt_q.rs1;
    assign d_rs2     = pkt_q.rs2;
    assign d_imm     = pkt_q.imm;
    assign d_rd      = pkt_q.rd;
    assign d_rd_we   = pkt_q.rd_we;
    assign d_type    = pkt_q.typ;
    assign d_func    = pkt_q.func;
    assign d_illegal = pkt_q.illegal;

endmodule

// File: tb/tb_idu.sv
// Directed self-checking bench for the idu decode stage.
module tb_idu;
    import idu_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     IR;
    logic [XLEN-1:0] ip;
    logic            IFU_valid;
    logic            IDU_ready;
    logic            jump;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            IDU_valid;
    logic            EXU_ready;
    logic [XLEN-1:0] d_ip;
    logic [XLEN-1:0] d_rs1;
    logic [XLEN-1:0] d_rs2;
    logic [XLEN-1:0] d_imm;
    logic [4:0]      d_rd;
    logic            d_rd_we;
    logic [2:0]      d_type;
    logic [3:0]      d_func;
    logic            d_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idu dut (
        .clk       (clk),
        .rst       (rst),
        .IR        (IR),
        .ip        (ip),
        .IFU_valid (IFU_valid),
        .IDU_ready (IDU_ready),
        .jump      (jump),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .IDU_valid (IDU_valid),
        .EXU_ready (EXU_ready),
        .d_ip      (d_ip),
        .d_rs1     (d_rs1),
        .d_rs2     (d_rs2),
        .d_imm     (d_imm),
        .d_rd      (d_rd),
        .d_rd_we   (d_rd_we),
        .d_type    (d_type),
        .d_func    (d_func),
        .d_illegal (d_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] word, input logic [31:0] addr);
        IR        = word;
        ip        = addr;
        IFU_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; IR = NOP; ip = '0; IFU_valid = 1'b1; jump = 1'b0;
        rs1_data = '0; rs2_data = '0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        EXU_ready = 1'b1;
        #12;
        check("rst_valid", IDU_valid, 0);
        check("rst_type", d_type, ALU_I);
        check("rst_imm", d_imm, 0);
        check("rst_func", d_func, 0);
        check("rst_ready", IDU_ready, 1);
        rst = 1'b0;

        tick();
        check("nop_valid", IDU_valid, 1);
        check("nop_type", d_type, ALU_I);
        check("nop_we", d_rd_we, 0);
        check("nop_imm", d_imm, 0);

        drive(32'hffdff06f, 32'h8);
        tick();
        check("jal_type", d_type, JAL);
        check("jal_imm", d_imm, 32'hfffffffc);
        check("jal_rd", d_rd, 0);
        check("jal_we", d_rd_we, 0);
        check("jal_ip", d_ip, 32'h8);

        drive(32'h00000463, 32'h10);
        tick();
        check("br1_type", d_type, BRANCH);
        check("br1_func", d_func, 0);
        check("br1_imm", d_imm, 32'h8);
        drive(32'hfe000ee3, 32'h14);
        tick();
        check("br2_valid", IDU_valid, 1);
        check("br2_type", d_type, BRANCH);
        check("br2_imm", d_imm, 32'hfffffffc);
        check("br2_ip", d_ip, 32'h14);

        // stall: addi x5,x0,7 waits while EXU holds off
        EXU_ready = 1'b0;
        drive(32'h00700293, 32'h18);
        #1;
        check("stall_ready", IDU_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", IDU_valid, 1);
            check("stall_imm", d_imm, 32'hfffffffc);
            check("stall_rdy", IDU_ready, 0);
        end
        EXU_ready = 1'b1;
        tick();
        check("resume_ip", d_ip, 32'h18);
        check("resume_imm", d_imm, 32'h7);
        check("resume_rd", d_rd, 5);
        check("resume_we", d_rd_we, 1);

        // jump drops addi x6,x0,0x55
        drive(32'h05500313, 32'h1c);
        jump = 1'b1;
        tick();
        check("jump_valid", IDU_valid, 0);
        jump = 1'b0;
        IFU_valid = 1'b0;
        tick();
        check("jump_drop", IDU_valid, 0);
        check("jump_keep_ip", d_ip, 32'h18);

        // add x3,x1,x2 with forwarding on rs1
        drive(32'h002081b3, 32'h40);
        rs1_data = 32'd5; rs2_data = 32'd6;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
        #1;
        check("rs1_addr", rs1_addr, 1);
        check("rs2_addr", rs2_addr, 2);
        tick();
        check("add_rs1_fwd", d_rs1, 9);
        check("add_rs2", d_rs2, 6);
        check("add_type", d_type, ALU_R);
        check("add_rd", d_rd, 3);
        check("add_we", d_rd_we, 1);
        check("add_imm", d_imm, 0);

        // sub x3,x1,x2 forwarding on rs2
        drive(32'h402081b3, 32'h44);
        wb_rd = 5'd2;
        tick();
        check("sub_func", d_func, 4'h8);
        check("sub_rs1", d_rs1, 5);
        check("sub_rs2_fwd", d_rs2, 9);

        // addi x1,x0,0: x0 stays zero even with wb to x0
        drive(32'h00000093, 32'h48);
        rs1_data = 32'h1234; wb_rd = 5'd0; wb_data = 32'h77;
        tick();
        check("x0_rs1", d_rs1, 0);
        wb_en = 1'b0;

        drive(32'h4010d093, 32'h4c);
        tick();
        check("srai_func", d_func, 4'hd);
        check("srai_imm", d_imm, 32'h401);

        drive(32'h123450b7, 32'h50);
        tick();
        check("lui_type", d_type, UPPER);
        check("lui_func", d_func, 1);
        check("lui_imm", d_imm, 32'h12345000);
        drive(32'h12345097, 32'h54);
        tick();
        check("auipc_func", d_func, 0);

        drive(32'h0020a223, 32'h58);
        tick();
        check("sw_type", d_type, STORE);
        check("sw_imm", d_imm, 4);
        check("sw_we", d_rd_we, 0);

        drive(32'hffffffff, 32'h5c);
        tick();
        check("bad_type", d_type, ALU_I);
        check("bad_we", d_rd_we, 0);
`ifdef IDU_ILLEGAL_DET_EN
        check("bad_illegal", d_illegal, 1);
`else
        check("bad_illegal", d_illegal, 0);
`endif
        check("bad_valid", IDU_valid, 1);

        // asynchronous reset between edges
        drive(32'h00700293, 32'h60);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", IDU_valid, 0);
        check("arst_ip", d_ip, 0);
        check("arst_rd", d_rd, 0);
        check("arst_type", d_type, ALU_I);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
